// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin sharing of the single L2 port between icache and dcache, one transaction at a time.
module l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic                  l2_mem_resp,
  input  logic [LINE_WIDTH-1:0] l2_rdata
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;
  state_t state;
  logic   last_d;
  logic   req_i, req_d, grant_d, grant_wr;
  assign req_i    = i_read | i_write;
  assign req_d    = d_read | d_write;
  // On a tie the side that did not win last time gets the port.
  assign grant_d  = req_d & (~req_i | ~last_d);
  assign grant_wr = grant_d ? d_write : i_write;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      last_d     <= 1'b1;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
    end else
      case (state)
        IDLE:
          if (req_i | req_d) begin
            state      <= grant_d ? SERVE_D : SERVE_I;
            last_d     <= grant_d;
            l2_write   <= grant_wr;
            l2_read    <= ~grant_wr;
            l2_address <= grant_d ? d_address : i_address;
            l2_wdata   <= grant_d ? d_wdata : i_wdata;
          end
        SERVE_I, SERVE_D:
          if (l2_mem_resp) begin
            state      <= RELEASE;
            l2_read    <= 1'b0;
            l2_write   <= 1'b0;
            l2_address <= '0;
            l2_wdata   <= '0;
          end
        default: state <= IDLE;
      endcase
  assign i_resp  = (state == SERVE_I) & l2_mem_resp;
  assign d_resp  = (state == SERVE_D) & l2_mem_resp;
  assign i_rdata = (state == SERVE_I) ? l2_rdata : '0;
  assign d_rdata = (state == SERVE_D) ? l2_rdata : '0;
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: scoreboard bench with an L2 responder model; expected grants queued at stimulus time.
module tb_l2_arbiter;
  logic         clk = 1'b0, reset_n = 1'b0;
  logic         i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [15:0]  i_address = '0, d_address = '0;
  logic [127:0] i_wdata = '0, d_wdata = '0;
  logic         i_resp, d_resp, l2_read, l2_write;
  logic [127:0] i_rdata, d_rdata, l2_wdata;
  logic [15:0]  l2_address;
  logic         l2_mem_resp = 1'b0;
  logic [127:0] l2_rdata = '0;

  l2_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_mem_resp(l2_mem_resp), .l2_rdata(l2_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         d;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0, failures = 0, served = 0, pulses = 0;
  logic active = 1'b0, prev = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] pat(input logic [15:0] a);
    return a == 16'h0120 ? {16{8'hA5}} : {8{a}};
  endfunction

  function automatic exp_t mk(input logic d, input logic wr, input logic [15:0] a, input logic [127:0] w);
    exp_t e;
    e.d = d; e.wr = wr; e.addr = a; e.wdata = w;
    return e;
  endfunction

  // L2 model: answers every strobe 5 cycles after first seeing it.
  initial forever begin
    logic [15:0] raddr;
    @(negedge clk);
    if (reset_n && (l2_read || l2_write)) begin
      raddr = l2_address;
      repeat (5) @(posedge clk);
      #2 l2_mem_resp = 1'b1; l2_rdata = pat(raddr);
      @(posedge clk);
      #2 l2_mem_resp = 1'b0; l2_rdata = '0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      active = 1'b0;
      prev   = 1'b0;
      chk("rst_ctrl", {l2_read, l2_write, i_resp, d_resp, l2_address}, '0);
      chk("rst_data", l2_wdata | i_rdata | d_rdata, '0);
    end else begin
      if ((l2_read || l2_write) && !prev) begin
        if (exp_q.size() == 0) chk("unexpected_grant", exp_q.size(), 1);
        else begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          chk("grant_op", {l2_read, l2_write}, cur.wr ? 2'b01 : 2'b10);
          chk("grant_addr", l2_address, cur.addr);
          chk("grant_wdata", l2_wdata, cur.wdata);
        end
      end else if (active && (l2_read || l2_write)) begin
        chk("hold_addr", l2_address, cur.addr);
        chk("hold_wdata", l2_wdata, cur.wdata);
      end
      if (i_resp || d_resp) begin
        pulses++;
        if (!active) chk("spurious_resp", {i_resp, d_resp}, 2'b00);
        else begin
          chk("resp_owner", {i_resp, d_resp}, cur.d ? 2'b01 : 2'b10);
          chk("rdata_owner", cur.d ? d_rdata : i_rdata, pat(cur.addr));
          chk("rdata_other", cur.d ? i_rdata : d_rdata, '0);
          active = 1'b0;
          served++;
        end
      end
      prev = l2_read | l2_write;
    end
  end

  task automatic wait_served(input int target);
    for (int k = 0; k < 300 && served < target; k++) @(negedge clk);
    chk("served_timeout", served, target);
  endtask

  task automatic wait_write;
    for (int k = 0; k < 100 && !l2_write; k++) @(negedge clk);
    chk("write_seen", l2_write, 1'b1);
  endtask

  task automatic do_reset;
    @(posedge clk); #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    int p0;
    i_read = 1'b1; i_address = 16'h0120;
    exp_q.push_back(mk(1'b0, 1'b0, 16'h0120, '0));
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("lat_read", l2_read, 1'b1);
    chk("lat_addr", l2_address, 16'h0120);
    wait_served(1);
    @(posedge clk); #1;
    chk("read_fall", l2_read, 1'b0);
    #1 i_read = 1'b0;

    i_read = 1'b1; i_address = 16'h0200;
    d_write = 1'b1; d_address = 16'h8000; d_wdata = {4{32'hDEADBEEF}};
    for (int n = 0; n < 2; n++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 16'h0200, '0));
      exp_q.push_back(mk(1'b1, 1'b1, 16'h8000, {4{32'hDEADBEEF}}));
    end
    do_reset();
    wait_served(5);
    @(posedge clk); #2 i_read = 1'b0; d_write = 1'b0;

    exp_q.push_back(mk(1'b1, 1'b1, 16'h4440, {8{16'h1357}}));
    @(posedge clk); #2 d_write = 1'b1; d_address = 16'h4440; d_wdata = {8{16'h1357}};
    wait_write();
    @(posedge clk); #2 d_address = 16'h1234; d_wdata = '1;
    @(negedge clk);
    chk("instab_addr", l2_address, 16'h4440);
    wait_served(6);
    @(posedge clk); #2 d_write = 1'b0;

    exp_q.push_back(mk(1'b1, 1'b1, 16'h0F00, {8{16'h2468}}));
    @(posedge clk); #2 d_read = 1'b1; d_write = 1'b1; d_address = 16'h0F00; d_wdata = {8{16'h2468}};
    wait_served(7);
    @(posedge clk); #2 d_read = 1'b0; d_write = 1'b0;

    exp_q.push_back(mk(1'b1, 1'b1, 16'h5550, {8{16'h9ABC}}));
    @(posedge clk); #2 d_write = 1'b1; d_address = 16'h5550; d_wdata = {8{16'h9ABC}};
    wait_write();
    @(posedge clk); #2 reset_n = 1'b0; d_write = 1'b0;
    #1 chk("rst_async", l2_write, 1'b0);
    p0 = pulses;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("no_late_resp", pulses, p0);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
